lane_request_tx: RTL and testbench

//  Host-side lane transmitter: frames one request (header + payload) into the 32-bit word stream that feeds an

---
 rtl/lane_request_tx.sv | 264 ++++++++++++++++++++++++++
 tb/tb_lane_request_tx.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_request_tx.sv
// lane_request_tx: frames one request (header + buffered payload) into the 32-bit lane word stream.
// Latency: header 1 cycle after lane_ready is seen in HDR; payload back-to-back after it; 1 idle GAP cycle.
// Backpressure: req_ready only in IDLE, pl_ready only in LOAD, lane_ready only sampled in HDR.
// Optional feature: define TX_CHECKSUM_EN to append an XOR trailer word after the payload.

// Payload store: simple synchronous FIFO with wrap-bit pointers.
module lane_request_tx_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 256
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic [W-1:0] pop_dat_o,
    output logic         empty_o,
    output logic         full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_dat_o = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer advance; guarded so an illegal push/pop cannot corrupt state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i && !full_o)
            wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_i && !empty_o)
            rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Pointer registers; reset flushes the buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_i && !full_o)
            mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
    end
endmodule

module lane_request_tx #(
    parameter int LANE_ID    = 0,
    parameter int MAX_LEN    = 255,
    parameter int FIFO_DEPTH = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_dest,
    input  logic [5:0]  req_tag,
    input  logic [7:0]  req_len,
    input  logic [13:0] req_user,
    input  logic        pl_valid,
    output logic        pl_ready,
    input  logic [31:0] pl_data,
    input  logic        lane_ready,
    output logic [31:0] lane_data,
    output logic        busy,
    output logic        err_pulse,
    output logic [15:0] pkt_count
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HDR,
        S_DATA,
        S_TRL,
        S_GAP
    } state_t;

    localparam logic [1:0] LANE     = LANE_ID[1:0];
    localparam logic [8:0] MAX_LEN9 = 9'(MAX_LEN);

    state_t      state_q, state_d;
    logic [1:0]  dest_q;
    logic [5:0]  tag_q;
    logic [7:0]  len_q;
    logic [13:0] user_q;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] lane_data_q, lane_data_d;
    logic        err_pulse_q, err_pulse_d;
    logic [15:0] pkt_count_q;
    logic        pkt_inc;
    logic        latch_desc;
`ifdef TX_CHECKSUM_EN
    logic [31:0] csum_q, csum_d;
`endif

    logic        req_acc;
    logic        req_bad;
    logic        pl_push;
    logic        fifo_pop;
    logic [31:0] fifo_dat;
    logic        fifo_empty;
    logic        fifo_full;
    logic [31:0] header;

    assign header    = {dest_q, LANE, len_q, tag_q, user_q};
    assign req_ready = (state_q == S_IDLE) && !reset;
    assign pl_ready  = (state_q == S_LOAD) && (cnt_q < len_q) && !fifo_full && !reset;
    assign req_acc   = req_valid && req_ready;
    assign pl_push   = pl_valid && pl_ready;
    assign req_bad   = (req_len == 8'd0) || ({1'b0, req_len} > MAX_LEN9) || (req_dest == 2'd3);

    assign lane_data = lane_data_q;
    assign busy      = (state_q != S_IDLE);
    assign err_pulse = err_pulse_q;
    assign pkt_count = pkt_count_q;

    lane_request_tx_fifo #(
        .W     (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (pl_push),
        .push_dat_i (pl_data),
        .pop_i      (fifo_pop),
        .pop_dat_o  (fifo_dat),
        .empty_o    (fifo_empty),
        .full_o     (fifo_full)
    );

    // Next-state and next lane word. lane_data is registered, so each state decides
    // the word that appears on the lane in the following cycle; DATA runs len+1
    // cycles so the final cycle can schedule the trailer or the idle word.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lane_data_d = 32'h0;
        err_pulse_d = 1'b0;
        pkt_inc     = 1'b0;
        latch_desc  = 1'b0;
        fifo_pop    = 1'b0;
`ifdef TX_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_acc) begin
                    if (req_bad) begin
                        err_pulse_d = 1'b1;
                    end else begin
                        latch_desc = 1'b1;
                        cnt_d      = 8'd0;
                        state_d    = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (pl_push) begin
                    if (cnt_q == len_q - 8'd1) begin
                        cnt_d   = 8'd0;
                        state_d = S_HDR;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            S_HDR: begin
                if (lane_ready) begin
                    lane_data_d = header;
                    cnt_d       = 8'd0;
                    state_d     = S_DATA;
`ifdef TX_CHECKSUM_EN
                    csum_d      = header;
`endif
                end
            end
            S_DATA: begin
                if (cnt_q != len_q) begin
                    // Whole packet is buffered, so the FIFO is never empty here.
                    if (!fifo_empty) begin
                        fifo_pop    = 1'b1;
                        lane_data_d = fifo_dat;
                        cnt_d       = cnt_q + 8'd1;
`ifdef TX_CHECKSUM_EN
                        csum_d      = csum_q ^ fifo_dat;
`endif
                    end
                end else begin
`ifdef TX_CHECKSUM_EN
                    lane_data_d = csum_q;
                    state_d     = S_TRL;
`else
                    state_d     = S_GAP;
`endif
                end
            end
            S_TRL: begin
                state_d = S_GAP;
            end
            S_GAP: begin
                pkt_inc = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, lane word, pulse and counter registers; reset truncates any packet in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            lane_data_q <= 32'h0;
            err_pulse_q <= 1'b0;
            pkt_count_q <= 16'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lane_data_q <= lane_data_d;
            err_pulse_q <= err_pulse_d;
            if (pkt_inc)
                pkt_count_q <= pkt_count_q + 16'h1;
        end
    end

    // Descriptor capture on a legal accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            dest_q <= 2'd0;
            tag_q  <= 6'd0;
            len_q  <= 8'd0;
            user_q <= 14'd0;
        end else if (latch_desc) begin
            dest_q <= req_dest;
            tag_q  <= req_tag;
            len_q  <= req_len;
            user_q <= req_user;
        end
    end

`ifdef TX_CHECKSUM_EN
    // Running XOR of header and payload words for the trailer.
    always_ff @(posedge clk) begin
        if (reset)
            csum_q <= 32'h0;
        else
            csum_q <= csum_d;
    end
`endif
endmodule

// File: tb/tb_lane_request_tx.sv
// Directed bench for lane_request_tx with a lane-word scoreboard.
// Main instance uses MAX_LEN=255; a second instance with MAX_LEN=8 covers the length limit.
// A forked monitor frames lane packets by header length and pops expected words.
module tb_lane_request_tx;
`ifdef TX_CHECKSUM_EN
    localparam int CSUM = 1;
`else
    localparam int CSUM = 0;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid, req_valid_b;
    logic [1:0]  req_dest;
    logic [5:0]  req_tag;
    logic [7:0]  req_len;
    logic [13:0] req_user;
    logic        pl_valid;
    logic [31:0] pl_data;
    logic        lane_ready;

    logic        req_ready, pl_ready, busy, err_pulse;
    logic [31:0] lane_data;
    logic [15:0] pkt_count;
    logic        req_ready_b, pl_ready_b, busy_b, err_pulse_b;
    logic [31:0] lane_data_b;
    logic [15:0] pkt_count_b;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q [$];
    bit          mon_en;

    lane_request_tx #(.LANE_ID(0), .MAX_LEN(255), .FIFO_DEPTH(256)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dest(req_dest), .req_tag(req_tag), .req_len(req_len), .req_user(req_user),
        .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_data(pl_data),
        .lane_ready(lane_ready), .lane_data(lane_data),
        .busy(busy), .err_pulse(err_pulse), .pkt_count(pkt_count)
    );

    lane_request_tx #(.LANE_ID(2), .MAX_LEN(8), .FIFO_DEPTH(16)) dut8 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_dest(req_dest), .req_tag(req_tag), .req_len(req_len), .req_user(req_user),
        .pl_valid(pl_valid), .pl_ready(pl_ready_b), .pl_data(pl_data),
        .lane_ready(lane_ready), .lane_data(lane_data_b),
        .busy(busy_b), .err_pulse(err_pulse_b), .pkt_count(pkt_count_b)
    );

    function automatic logic [31:0] mk_hdr(input logic [1:0] d, input logic [5:0] t,
                                           input logic [7:0] l, input logic [13:0] u);
        return {d, 2'd0, l, t, u};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Frames lane traffic: a nonzero word while idle is a header, then len payload
    // words (plus trailer), then one mandatory idle word.
    task automatic monitor();
        bit          in_pkt = 0;
        bit          gap_chk = 0;
        int          rem = 0;
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                in_pkt  = 0;
                gap_chk = 0;
            end else if (gap_chk) begin
                chk("gap word", lane_data, 32'h0);
                gap_chk = 0;
            end else if (in_pkt || lane_data != 32'h0) begin
                chk("scoreboard nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    if (!in_pkt) begin
                        chk("header word", lane_data, e);
                        rem    = int'(e[27:20]) + CSUM;
                        in_pkt = 1;
                    end else begin
                        chk("payload word", lane_data, e);
                        rem--;
                        if (rem == 0) begin
                            in_pkt  = 0;
                            gap_chk = 1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic send_req(input bit to_b, input logic [1:0] d, input logic [5:0] t,
                            input logic [7:0] l, input logic [13:0] u);
        bit ok = 0;
        req_dest = d; req_tag = t; req_len = l; req_user = u;
        if (to_b) req_valid_b = 1'b1; else req_valid = 1'b1;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            ok = to_b ? req_ready_b : req_ready;
            @(posedge clk); #1;
        end
        req_valid   = 1'b0;
        req_valid_b = 1'b0;
        chk("descriptor accepted", 32'(ok), 32'd1);
    endtask

    task automatic send_pkt(input logic [1:0] d, input logic [5:0] t, input logic [13:0] u,
                            input logic [31:0] words [$], input bit rnd);
        logic [31:0] h;
        logic [31:0] x;
        int          i = 0;
        h = mk_hdr(d, t, 8'(words.size()), u);
        x = h;
        exp_q.push_back(h);
        foreach (words[j]) begin
            exp_q.push_back(words[j]);
            x = x ^ words[j];
        end
        if (CSUM != 0) exp_q.push_back(x);
        send_req(1'b0, d, t, 8'(words.size()), u);
        for (int b = 0; b < 5000 && i < words.size(); b++) begin
            pl_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            pl_data  = words[i];
            @(negedge clk);
            if (pl_valid && pl_ready) i++;
            @(posedge clk); #1;
        end
        pl_valid = 1'b0;
        chk("payload accepted", i, words.size());
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int k = 0; k < 2000 && !done; k++) begin
            @(negedge clk);
            done = !busy;
        end
        chk("return to idle", 32'(done), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] w [$];
        logic [31:0] h;
        bit          found;

        reset = 1'b1; req_valid = 1'b0; req_valid_b = 1'b0; req_dest = 2'd0; req_tag = 6'd0;
        req_len = 8'd0; req_user = 14'd0; pl_valid = 1'b0; pl_data = 32'h0; lane_ready = 1'b1;
        mon_en = 1'b1;
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset lane_data", lane_data, 32'h0);
        chk("reset req_ready", 32'(req_ready), 32'd0);
        chk("reset pl_ready", 32'(pl_ready), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset err_pulse", 32'(err_pulse), 32'd0);
        chk("reset pkt_count", 32'(pkt_count), 32'd0);
        chk("reset b lane_data", lane_data_b, 32'h0);
        chk("reset b req_ready", {30'd0, req_ready_b, pl_ready_b}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("idle req_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;

        // T1: basic packet, lane always ready
        w = '{32'hA1, 32'hA2, 32'hA3};
        send_pkt(2'd1, 6'd5, 14'd0, w, 1'b0);
        wait_idle();
        chk("T1 pkt_count", 32'(pkt_count), 32'd1);

        // T2: lane not ready for 10 cycles in HDR, then drops again during DATA
        lane_ready = 1'b0;
        w = '{32'hB1, 32'hB2, 32'hB3, 32'hB4};
        h = mk_hdr(2'd2, 6'd9, 8'd4, 14'h123);
        send_pkt(2'd2, 6'd9, 14'h123, w, 1'b0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("T2 lane idle in HDR", lane_data, 32'h0);
            chk("T2 busy in HDR", 32'(busy), 32'd1);
            @(posedge clk); #1;
        end
        lane_ready = 1'b1;
        @(negedge clk);
        chk("T2 lane idle before edge", lane_data, 32'h0);
        @(negedge clk);
        chk("T2 header latency", lane_data, h);
        lane_ready = 1'b0;
        wait_idle();
        lane_ready = 1'b1;
        chk("T2 pkt_count", 32'(pkt_count), 32'd2);

        // T3: illegal descriptors are dropped with an error pulse
        send_req(1'b0, 2'd1, 6'd1, 8'd0, 14'd0);
        @(negedge clk);
        chk("T3 len0 err_pulse", 32'(err_pulse), 32'd1);
        chk("T3 len0 lane_data", lane_data, 32'h0);
        chk("T3 len0 req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        chk("T3 err_pulse one cycle", 32'(err_pulse), 32'd0);
        @(posedge clk); #1;
        send_req(1'b0, 2'd3, 6'd2, 8'd2, 14'd7);
        @(negedge clk);
        chk("T3 dest3 err_pulse", 32'(err_pulse), 32'd1);
        chk("T3 dest3 busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        send_req(1'b1, 2'd0, 6'd3, 8'd9, 14'd0);
        @(negedge clk);
        chk("T3 len9 err_pulse", 32'(err_pulse_b), 32'd1);
        chk("T3 len9 req_ready", 32'(req_ready_b), 32'd1);
        chk("T3 len9 lane_data", lane_data_b, 32'h0);
        chk("T3 len9 pkt_count", 32'(pkt_count_b), 32'd0);
        chk("T3 len9 busy", 32'(busy_b), 32'd0);
        @(posedge clk); #1;
        chk("T3 pkt_count", 32'(pkt_count), 32'd2);

        // T4: maximum length, random pl_valid, payload includes zero
        w = {};
        for (int k = 0; k < 255; k++) w.push_back(32'(k));
        send_pkt(2'd2, 6'h3F, 14'h3FFF, w, 1'b1);
        wait_idle();
        chk("T4 pkt_count", 32'(pkt_count), 32'd3);

        // T5: reset while word 2 of 4 is on the lane
        w = '{32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003, 32'hC0DE0004};
        send_pkt(2'd0, 6'd4, 14'h55, w, 1'b0);
        found = 0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge clk);
            found = (lane_data === 32'hC0DE0002);
        end
        chk("T5 reached word 2", 32'(found), 32'd1);
        mon_en = 1'b0;
        reset  = 1'b1;
        @(negedge clk);
        chk("T5 lane_data after reset", lane_data, 32'h0);
        chk("T5 busy after reset", 32'(busy), 32'd0);
        chk("T5 pkt_count after reset", 32'(pkt_count), 32'd0);
        reset = 1'b0;
        exp_q.delete();
        mon_en = 1'b1;
        @(posedge clk); #1;
        w = '{32'hD1, 32'h0};
        send_pkt(2'd1, 6'd6, 14'h2, w, 1'b0);
        wait_idle();
        chk("T5 clean packet counted", 32'(pkt_count), 32'd1);

        // T6: small packet whose trailer (when enabled) is header ^ 1 ^ 2
        w = '{32'h1, 32'h2};
        send_pkt(2'd0, 6'd10, 14'h1ABC, w, 1'b0);
        wait_idle();
        chk("T6 pkt_count", 32'(pkt_count), 32'd2);

        repeat (4) @(posedge clk);
        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
